// File: rtl/wb_tgt_pkg.sv
// Shared types and configuration checks for the pipelined Wishbone RAM target.
package wb_tgt_pkg;

  localparam int DAT_W  = 16;
  localparam int SEL_W  = 2;
  localparam int LANE_W = DAT_W / SEL_W;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [DAT_W-1:0] rdata;
  } rsp_t;

  // The response struct has a fixed data width, so the data bus must match it.
  function automatic bit cfgOk(int latency, int maxOut, int memAw, int adrW, int datW, int selW);
    return (latency >= 1) && (latency <= 8) &&
           (maxOut >= 1) && (maxOut <= latency + 1) &&
           (memAw >= 1) && (memAw <= adrW) &&
           (datW == DAT_W) && (selW >= 1) && ((datW % selW) == 0);
  endfunction

endpackage

// File: rtl/wb_tgt_dly.sv
// Fixed-length response delay line; flush drops every in-flight response.
module wb_tgt_dly
  import wb_tgt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic async_rst_i,
  input  logic sync_rst_i,
  input  logic flush_i,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  rsp_t stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (sync_rst_i || flush_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rsp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target: word-addressed RAM with fixed response latency,
// in-order ACK/ERR and a bounded number of outstanding requests.
module wb_tgt_mem
  import wb_tgt_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int MEM_AW     = 8,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  tgt_cyc_i,
  input  logic                  tgt_stb_i,
  input  logic                  tgt_we_i,
  input  logic                  tgt_lock_i,
  input  logic [SEL_WIDTH-1:0]  tgt_sel_i,
  input  logic [ADR_WIDTH-1:0]  tgt_adr_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGA_WIDTH-1:0]  tgt_tga_i,
  input  logic [TGC_WIDTH-1:0]  tgt_tgc_i,
  input  logic [TGWD_WIDTH-1:0] tgt_tgd_i,
  output logic                  tgt_ack_o,
  output logic                  tgt_err_o,
  output logic                  tgt_rty_o,
  output logic                  tgt_stall_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGRD_WIDTH-1:0] tgt_tgd_o
);

  localparam int LaneW = DAT_WIDTH / SEL_WIDTH;
  localparam int CntW  = $clog2(MAX_OUT + 1);
  localparam int Words = 1 << MEM_AW;

  if (!cfgOk(LATENCY, MAX_OUT, MEM_AW, ADR_WIDTH, DAT_WIDTH, SEL_WIDTH)) begin : gen_cfg_err
    $error("wb_tgt_mem: illegal parameter combination");
  end

  logic [DAT_WIDTH-1:0] mem_q [Words];
  logic [CntW-1:0]      outCnt_q, outCnt_d;
  logic [MEM_AW-1:0]    memIdx;
  logic                 accept, inRange;
  rsp_t                 rspIn, rspOut;
  logic                 unusedInputs;

  assign unusedInputs = ^{tgt_lock_i, tgt_tga_i, tgt_tgc_i, tgt_tgd_i};

  assign memIdx  = tgt_adr_i[MEM_AW-1:0];
  assign inRange = (tgt_adr_i >> MEM_AW) == '0;
  assign accept  = tgt_cyc_i & tgt_stb_i & ~tgt_stall_o & ~sync_rst_i;

  // Read data is sampled from the pre-write RAM contents on the accepting edge.
  always_comb begin
    rspIn       = '0;
    rspIn.valid = accept;
    rspIn.err   = accept & ~inRange;
    if (accept && inRange && !tgt_we_i) rspIn.rdata = mem_q[memIdx];
  end

  always_ff @(posedge clk_i) begin
    if (accept && inRange && tgt_we_i) begin
      for (int l = 0; l < SEL_WIDTH; l++) begin
        if (tgt_sel_i[l]) mem_q[memIdx][l*LaneW +: LaneW] <= tgt_dat_i[l*LaneW +: LaneW];
      end
    end
  end

  wb_tgt_dly #(.DEPTH(LATENCY)) u_dly (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .sync_rst_i  (sync_rst_i),
    .flush_i     (~tgt_cyc_i),
    .rsp_i       (rspIn),
    .rsp_o       (rspOut)
  );

  // An accept and a response in the same cycle cancel out.
  always_comb begin
    outCnt_d = outCnt_q;
    if (!tgt_cyc_i)                   outCnt_d = '0;
    else if (accept && !rspOut.valid) outCnt_d = outCnt_q + CntW'(1);
    else if (!accept && rspOut.valid) outCnt_d = outCnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i)     outCnt_q <= '0;
    else if (sync_rst_i) outCnt_q <= '0;
    else                 outCnt_q <= outCnt_d;
  end

  assign tgt_stall_o = (outCnt_q == CntW'(MAX_OUT));
  assign tgt_ack_o   = tgt_cyc_i & rspOut.valid & ~rspOut.err;
  assign tgt_err_o   = tgt_cyc_i & rspOut.valid & rspOut.err;
  assign tgt_dat_o   = (tgt_cyc_i && rspOut.valid) ? rspOut.rdata : '0;
  assign tgt_rty_o   = 1'b0;
  assign tgt_tgd_o   = '0;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Scoreboard bench for wb_tgt_mem: a bus model predicts acceptance, RAM contents
// and response timing; every cycle the DUT outputs are compared against it.
module tb_wb_tgt_mem;

  localparam int LAT  = 2;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        asyncRst = 1'b0, syncRst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [15:0] adr = 16'h0, dat = 16'h0;
  logic        tga = 1'b0, tgc = 1'b0, tgdIn = 1'b0;
  logic        ack, err, rty, stall, tgdOut;
  logic [15:0] datOut;

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] modelMem [256];
  int          edgeNo = 0, modelCnt = 0;
  int          vectors = 0, miscompares = 0;
  bit          respCycle = 1'b0, lastAcc = 1'b0;

  always #5 clk = ~clk;

  wb_tgt_mem #(
    .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2), .TGA_WIDTH(1), .TGC_WIDTH(1),
    .TGRD_WIDTH(1), .TGWD_WIDTH(1), .MEM_AW(8), .LATENCY(LAT), .MAX_OUT(MAXO)
  ) dut (
    .clk_i(clk), .async_rst_i(asyncRst), .sync_rst_i(syncRst),
    .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we), .tgt_lock_i(lock),
    .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat),
    .tgt_tga_i(tga), .tgt_tgc_i(tgc), .tgt_tgd_i(tgdIn),
    .tgt_ack_o(ack), .tgt_err_o(err), .tgt_rty_o(rty), .tgt_stall_o(stall),
    .tgt_dat_o(datOut), .tgt_tgd_o(tgdOut)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Bus model: decides acceptance from its own outstanding count and pushes the
  // expected response, due LAT-1 edges after the accepting edge.
  always @(posedge clk) begin : modelBlk
    exp_t       e;
    logic [7:0] idx;
    bit         inR;
    edgeNo++;
    lastAcc = 1'b0;
    if (asyncRst || syncRst || !cyc) begin
      q.delete();
      modelCnt = 0;
    end else begin
      lastAcc = stb && (modelCnt != MAXO);
      if (lastAcc) begin
        idx    = adr[7:0];
        inR    = (adr[15:8] == 8'h00);
        e.due  = edgeNo + LAT - 1;
        e.err  = !inR;
        e.data = (inR && !we) ? modelMem[idx] : 16'h0000;
        q.push_back(e);
        if (inR && we) begin
          if (sel[0]) modelMem[idx][7:0]  = dat[7:0];
          if (sel[1]) modelMem[idx][15:8] = dat[15:8];
        end
      end
      modelCnt = modelCnt + int'(lastAcc) - int'(respCycle);
    end
    respCycle = 1'b0;
  end

  // Async reset drops everything in flight immediately.
  always @(posedge asyncRst) begin
    q.delete();
    modelCnt = 0;
  end

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin : checkBlk
    exp_t e;
    bit   expR;
    if (asyncRst || syncRst || cyc || stb || edgeNo > 0) begin
      expR = cyc && (q.size() > 0) && (q[0].due == edgeNo);
      if (expR) begin
        e = q.pop_front();
        respCycle = 1'b1;
        checkOutput("ack", ack, !e.err);
        checkOutput("err", err, e.err);
        checkOutput("dat", datOut, e.data);
      end else begin
        checkOutput("ackIdle", ack, 0);
        checkOutput("errIdle", err, 0);
        checkOutput("datIdle", datOut, 0);
      end
      checkOutput("stall", stall, modelCnt == MAXO);
      checkOutput("rty", rty, 0);
      checkOutput("tgd", tgdOut, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold one request on the bus until the model says it was accepted.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    int tries = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    do begin
      tick();
      tries++;
    end while (!lastAcc && tries < 16);
    if (!lastAcc) checkOutput("acceptTimeout", tries, 0);
  endtask

  task automatic idle(input int n);
    stb = 1'b0; we = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 asyncRst = 1'b1;
    repeat (3) tick();
    asyncRst = 1'b0;
    tick();
    cyc = 1'b1;
    tick();

    $display("[TB] write/read round trip");
    applyStimulus(1'b1, 16'h0010, 16'hBEEF, 2'b11);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    idle(4);

    $display("[TB] partial lane write");
    applyStimulus(1'b1, 16'h0020, 16'h0000, 2'b11);
    applyStimulus(1'b1, 16'h0020, 16'h1234, 2'b01);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b11);
    idle(4);

    $display("[TB] back-to-back burst with stall");
    applyStimulus(1'b1, 16'h0030, 16'hA5A5, 2'b11);
    applyStimulus(1'b0, 16'h0030, 16'h0000, 2'b11);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b11);
    idle(5);

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b0, 16'h0100, 16'h0000, 2'b11);
    applyStimulus(1'b1, 16'h0120, 16'hFFFF, 2'b11);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b11);
    idle(4);

    $display("[TB] cycle abort");
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    applyStimulus(1'b0, 16'h0030, 16'h0000, 2'b11);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) tick();
    checkOutput("abortStall", stall, 0);
    cyc = 1'b1;
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    idle(4);

    $display("[TB] async reset mid-burst");
    applyStimulus(1'b1, 16'h0040, 16'hCAFE, 2'b11);
    applyStimulus(1'b0, 16'h0040, 16'h0000, 2'b11);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    asyncRst = 1'b1;
    #1;
    checkOutput("rstAck", ack, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstDat", datOut, 0);
    checkOutput("rstStall", stall, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) tick();
    asyncRst = 1'b0;
    tick();
    cyc = 1'b1;
    applyStimulus(1'b0, 16'h0040, 16'h0000, 2'b11);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 2'b11);
    idle(4);

    $display("[TB] sync reset drops pending response");
    applyStimulus(1'b0, 16'h0030, 16'h0000, 2'b11);
    stb = 1'b0; syncRst = 1'b1;
    tick();
    syncRst = 1'b0;
    idle(3);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 2'b11);
    idle(5);

    checkOutput("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
